// File: rtl/sdram_pkt_capture.sv
// Passive SDRAM command-bus monitor: decodes commands, tracks open rows per bank, and queues
// timestamped packets into a FIFO. Define PKT_FILTER_EN to add a per-command capture mask.
module sdram_pkt_capture #(
    parameter int unsigned BANK_W  = 2,
    parameter int unsigned ROW_W   = 13,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CAS_LAT = 2,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned ID_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cs_n,
    input  logic                       ras_n,
    input  logic                       cas_n,
    input  logic                       we_n,
    input  logic [BANK_W-1:0]          ba,
    input  logic [ROW_W-1:0]           addr,
    input  logic [DATA_W-1:0]          dq,
`ifdef PKT_FILTER_EN
    input  logic [7:0]                 filter_mask,
`endif
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [TS_W-1:0]            pkt_timestamp,
    output logic [ID_W-1:0]            pkt_id,
    output logic [2:0]                 pkt_command,
    output logic [BANK_W-1:0]          pkt_bank,
    output logic [ROW_W-1:0]           pkt_row,
    output logic [COL_W-1:0]           pkt_col,
    output logic [DATA_W-1:0]          pkt_data,
    output logic                       pkt_err,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int unsigned NB    = 1 << BANK_W;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ID_W-1:0]   id;
        logic [2:0]        cmd;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
        logic              err;
    } pkt_t;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [NB-1:0]    open_q, open_d;
    logic [ROW_W-1:0] open_row_q [NB];
    logic [ROW_W-1:0] open_row_d [NB];

    pkt_t             dl_q [CAS_LAT];
    pkt_t             dl_d [CAS_LAT];
    logic [CAS_LAT-1:0] dl_vld_q, dl_vld_d;

    pkt_t             mem_q [DEPTH];
    pkt_t             mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [2:0]       cmd_c;
    logic             cmd_hit_c;
    logic             capture_c;
    pkt_t             new_pkt_c;
    pkt_t             push_pkt_c;
    logic             exit_vld_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    assign cmd_c     = {ras_n, cas_n, we_n};
    assign cmd_hit_c = !cs_n && (cmd_c != CMD_NOP);

`ifdef PKT_FILTER_EN
    assign capture_c = cmd_hit_c && filter_mask[cmd_c];
`else
    assign capture_c = cmd_hit_c;
`endif

    // Command decode and bank state; bank tracking follows every command, filtered or not.
    always_comb begin
        new_pkt_c      = '0;
        new_pkt_c.ts   = ts_q;
        new_pkt_c.id   = id_q;
        new_pkt_c.cmd  = cmd_c;
        new_pkt_c.bank = ba;
        new_pkt_c.row  = addr;
        open_d         = open_q;
        open_row_d     = open_row_q;
        case (cmd_c)
            CMD_ACT: begin
                if (cmd_hit_c) begin
                    open_d[ba]     = 1'b1;
                    open_row_d[ba] = addr;
                end
            end
            CMD_PRE: begin
                if (cmd_hit_c) begin
                    if (addr[10]) open_d = '0;
                    else          open_d[ba] = 1'b0;
                end
            end
            CMD_RD, CMD_WR: begin
                new_pkt_c.row = open_q[ba] ? open_row_q[ba] : '0;
                new_pkt_c.col = addr[COL_W-1:0];
                new_pkt_c.err = !open_q[ba];
                if (cmd_c == CMD_WR) new_pkt_c.data = dq;
            end
            default: ;
        endcase
    end

    // Counters and the equal-length delay line that keeps writes ordered behind late read data.
    always_comb begin
        ts_d        = ts_q + TS_W'(1);
        id_d        = capture_c ? id_q + ID_W'(1) : id_q;
        dl_d[0]     = new_pkt_c;
        dl_vld_d[0] = capture_c;
        for (int unsigned i = 1; i < CAS_LAT; i++) begin
            dl_d[i]     = dl_q[i-1];
            dl_vld_d[i] = dl_vld_q[i-1];
        end
        exit_vld_c = dl_vld_q[CAS_LAT-1];
        push_pkt_c = dl_q[CAS_LAT-1];
        if (push_pkt_c.cmd == CMD_RD) push_pkt_c.data = dq;
    end

    // Output FIFO; a push into a full FIFO survives only if the head leaves in the same cycle.
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        pop_c   = (count_q != '0) && pkt_ready;
        push_c  = exit_vld_c && (!full_c || pop_c);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_c) begin
            mem_d[wr_q] = push_pkt_c;
            wr_d        = wr_q + AW'(1);
        end
        if (pop_c) rd_d = rd_q + AW'(1);
        if (exit_vld_c && !push_c) ovf_d = 1'b1;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q     <= '0;
            id_q     <= '0;
            open_q   <= '0;
            dl_vld_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < NB; i++)      open_row_q[i] <= '0;
            for (int unsigned i = 0; i < CAS_LAT; i++) dl_q[i]       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)   mem_q[i]      <= '0;
        end else begin
            ts_q       <= ts_d;
            id_q       <= id_d;
            open_q     <= open_d;
            open_row_q <= open_row_d;
            dl_q       <= dl_d;
            dl_vld_q   <= dl_vld_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pkt_valid     = (count_q != '0);
    assign pkt_timestamp = mem_q[rd_q].ts;
    assign pkt_id        = mem_q[rd_q].id;
    assign pkt_command   = mem_q[rd_q].cmd;
    assign pkt_bank      = mem_q[rd_q].bank;
    assign pkt_row       = mem_q[rd_q].row;
    assign pkt_col       = mem_q[rd_q].col;
    assign pkt_data      = mem_q[rd_q].data;
    assign pkt_err       = mem_q[rd_q].err;
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_sdram_pkt_capture.sv
// Bench for sdram_pkt_capture: directed scenarios plus random traffic against a queue-based model.
module tb_sdram_pkt_capture;

    localparam int DEPTH   = 16;
    localparam int CAS_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq;
    logic        pkt_valid, pkt_ready;
    logic [31:0] pkt_timestamp, pkt_id;
    logic [2:0]  pkt_command;
    logic [1:0]  pkt_bank;
    logic [12:0] pkt_row;
    logic [9:0]  pkt_col;
    logic [15:0] pkt_data;
    logic        pkt_err;
    logic [4:0]  fifo_count;
    logic        overflow;

    always #5 clk = ~clk;

    sdram_pkt_capture dut (
        .clk(clk), .reset_n(reset_n),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .dq(dq),
`ifdef PKT_FILTER_EN
        .filter_mask(8'hFF),
`endif
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_timestamp(pkt_timestamp), .pkt_id(pkt_id), .pkt_command(pkt_command),
        .pkt_bank(pkt_bank), .pkt_row(pkt_row), .pkt_col(pkt_col), .pkt_data(pkt_data),
        .pkt_err(pkt_err), .fifo_count(fifo_count), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] ts;
        logic [31:0] id;
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [15:0] data;
        logic        err;
        int          due;
    } mpkt_t;

    int          nchk  = 0;
    int          nfail = 0;
    bit          mo_open [4];
    logic [12:0] mo_row  [4];
    int          cyc;
    logic [31:0] mo_id;
    bit          mo_ovf;
    mpkt_t       pend[$];
    mpkt_t       expq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exv);
        nchk++;
        assert (obs === exv) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin mo_open[b] = 0; mo_row[b] = '0; end
        cyc = 0; mo_id = '0; mo_ovf = 0;
        pend.delete(); expq.delete();
    endtask

    // One clock edge of behaviour, using the inputs held during the cycle that just ended.
    task automatic model_step();
        mpkt_t p;
        int    was;
        bit    pop;
        logic [2:0] c;
        was = expq.size();
        pop = (was > 0) && pkt_ready;
        if (pop) void'(expq.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            if (p.cmd == 3'b101) p.data = dq;
            if (was == DEPTH && !pop) mo_ovf = 1;
            else expq.push_back(p);
        end
        c = {ras_n, cas_n, we_n};
        if (!cs_n && c != 3'b111) begin
            p.ts = 32'(cyc); p.id = mo_id; p.cmd = c; p.bank = ba; p.row = addr;
            p.col = '0; p.data = '0; p.err = 0; p.due = cyc + CAS_LAT;
            if (c == 3'b101 || c == 3'b100) begin
                p.row = mo_open[ba] ? mo_row[ba] : 13'h0;
                p.col = addr[9:0];
                p.err = !mo_open[ba];
                if (c == 3'b100) p.data = dq;
            end
            if (c == 3'b011) begin mo_open[ba] = 1; mo_row[ba] = addr; end
            if (c == 3'b010) begin
                if (addr[10]) for (int b = 0; b < 4; b++) mo_open[b] = 0;
                else mo_open[ba] = 0;
            end
            pend.push_back(p);
            mo_id = mo_id + 32'd1;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("valid", pkt_valid, (expq.size() != 0));
        chk("count", fifo_count, 64'(expq.size()));
        chk("overflow", overflow, mo_ovf);
        if (expq.size() > 0) begin
            chk("ts",   pkt_timestamp, expq[0].ts);
            chk("id",   pkt_id,        expq[0].id);
            chk("cmd",  pkt_command,   expq[0].cmd);
            chk("bank", pkt_bank,      expq[0].bank);
            chk("row",  pkt_row,       expq[0].row);
            chk("col",  pkt_col,       expq[0].col);
            chk("data", pkt_data,      expq[0].data);
            chk("err",  pkt_err,       expq[0].err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic cmd_cyc(input logic cs, input logic [2:0] c, input logic [1:0] b,
                           input logic [12:0] a, input logic [15:0] d, input logic rdy);
        cs_n = cs; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dq = d; pkt_ready = rdy;
        tick();
    endtask

    task automatic nop(input logic rdy);
        cmd_cyc(1'b1, 3'b111, 2'($urandom), 13'($urandom), 16'($urandom), rdy);
    endtask

    task automatic do_reset(input bit check);
        cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; pkt_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_valid", pkt_valid, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_ovf",   overflow, 0);
            chk("rst_cmd",   pkt_command, 0);
            chk("rst_row",   pkt_row, 0);
            chk("rst_bank",  pkt_bank, 0);
            chk("rst_ts",    pkt_timestamp, 0);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
        ba = '0; addr = '0; dq = '0; pkt_ready = 1'b0;
        #1;
        do_reset(0);
        check_all();

        // ACTIVE then READ with data CAS_LAT cycles later
        cmd_cyc(1'b0, 3'b011, 2'd1, 13'h0123, 16'($urandom), 1'b0);
        cmd_cyc(1'b0, 3'b101, 2'd1, 13'h0045, 16'($urandom), 1'b0);
        chk("lat_early", pkt_valid, 0);
        nop(1'b0);
        chk("lat_valid", pkt_valid, 1);
        cmd_cyc(1'b1, 3'b111, 2'd0, 13'h0, 16'hBEEF, 1'b0);
        chk("r18_id0",  pkt_id, 0);
        chk("r18_cmd0", pkt_command, 3'b011);
        chk("r18_row0", pkt_row, 13'h0123);
        nop(1'b1);
        chk("r18_id1",   pkt_id, 1);
        chk("r18_cmd1",  pkt_command, 3'b101);
        chk("r18_row1",  pkt_row, 13'h0123);
        chk("r18_col1",  pkt_col, 10'h045);
        chk("r18_data1", pkt_data, 16'hBEEF);
        chk("r18_err1",  pkt_err, 0);

        // WRITE to a closed bank
        do_reset(0);
        cmd_cyc(1'b0, 3'b100, 2'd2, 13'h0010, 16'h1234, 1'b0);
        nop(1'b0); nop(1'b0);
        chk("r19_err",  pkt_err, 1);
        chk("r19_row",  pkt_row, 0);
        chk("r19_data", pkt_data, 16'h1234);

        // PRECHARGE-all closes every bank
        do_reset(0);
        for (int b = 0; b < 4; b++) cmd_cyc(1'b0, 3'b011, 2'(b), 13'(100 + b), 16'($urandom), 1'b0);
        cmd_cyc(1'b0, 3'b010, 2'd0, 13'h0400, 16'($urandom), 1'b0);
        cmd_cyc(1'b0, 3'b101, 2'd3, 13'h0007, 16'($urandom), 1'b0);
        for (int k = 0; k < 3; k++) nop(1'b0);
        for (int k = 0; k < 5; k++) nop(1'b1);
        nop(1'b0);
        chk("r20_cmd", pkt_command, 3'b101);
        chk("r20_err", pkt_err, 1);
        chk("r20_row", pkt_row, 0);

        // Overflow: 17 writes into a 16-deep FIFO with no consumer
        do_reset(0);
        for (int k = 0; k < 17; k++) cmd_cyc(1'b0, 3'b100, 2'd0, 13'(k), 16'($urandom), 1'b0);
        for (int k = 0; k < 3; k++) nop(1'b0);
        chk("r21_count", fifo_count, 16);
        chk("r21_ovf",   overflow, 1);
        for (int k = 0; k < 16; k++) begin
            chk("r21_id", pkt_id, 64'(k));
            nop(1'b1);
        end
        chk("r21_empty",  pkt_valid, 0);
        chk("r21_sticky", overflow, 1);

        // Full FIFO, push and pop in the same cycle
        do_reset(0);
        for (int k = 0; k < 16; k++) cmd_cyc(1'b0, 3'b100, 2'd1, 13'(k), 16'($urandom), 1'b0);
        for (int k = 0; k < 3; k++) nop(1'b0);
        chk("r22_full", fifo_count, 16);
        cmd_cyc(1'b0, 3'b100, 2'd1, 13'h0055, 16'($urandom), 1'b0);
        nop(1'b0);
        nop(1'b1);
        chk("r22_count", fifo_count, 16);
        chk("r22_ovf",   overflow, 0);
        chk("r22_head",  pkt_id, 1);

        // Reset with a READ still in flight
        do_reset(0);
        cmd_cyc(1'b0, 3'b011, 2'd0, 13'h1ABC, 16'($urandom), 1'b0);
        cmd_cyc(1'b0, 3'b101, 2'd0, 13'h0003, 16'($urandom), 1'b0);
        nop(1'b0);
        chk("r23_pre", pkt_valid, 1);
        do_reset(1);
        cmd_cyc(1'b0, 3'b011, 2'd1, 13'h0055, 16'($urandom), 1'b0);
        for (int k = 0; k < 4; k++) nop(1'b0);
        chk("r23_id",    pkt_id, 0);
        chk("r23_ts",    pkt_timestamp, 0);
        chk("r23_count", fifo_count, 1);

        // Random traffic: slow consumer first, then fast
        do_reset(0);
        for (int k = 0; k < 500; k++) begin
            logic rdy;
            rdy = (k < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cmd_cyc(($urandom_range(0, 4) == 0), 3'($urandom), 2'($urandom), 13'($urandom),
                    16'($urandom), rdy);
        end
        for (int k = 0; k < 40; k++) nop(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
